mod_classify_seq: RTL and testbench

Parametrised sequential modulation classifier for the PYNQ-Z2 design. It fetches a run of feature records from an external single-port BRAM. Each record is three words: sigma_ap, sigma_af, sigma_dp. It classifies every record with a fixed priority rule set and streams one modulation code per record over a valid/ready handshake. Software or a controller starts a run with start, base_addr and num_rec; the block reports busy and done.

---
 rtl/mod_classify_pkg.sv | 38 +++
 rtl/mod_classify_seq_rule_eval.sv | 59 +++++
 rtl/mod_classify_seq.sv | 186 ++++++++++++++++++
 tb/tb_mod_classify_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_classify_pkg.sv
// Shared definitions for the sequential modulation classifier: result codes,
// rule thresholds and the controller state encoding.
package mod_classify_pkg;

    // Modulation result codes
    localparam logic [2:0] MOD_UNKNOWN = 3'd0;
    localparam logic [2:0] MOD_AM      = 3'd1;
    localparam logic [2:0] MOD_FM      = 3'd2;
    localparam logic [2:0] MOD_PSK     = 3'd3;
    localparam logic [2:0] MOD_ASK     = 3'd4;
    localparam logic [2:0] MOD_FSK     = 3'd5;

    // Rule thresholds; these are zero-extended to the feature width at the point of use.
    // FM and PSK share the same upper bound on sigma_ap.
    localparam int unsigned TH_AM_AP_MIN  = 70;
    localparam int unsigned TH_AM_AF_MIN  = 100;
    localparam int unsigned TH_AM_DP_MAX  = 200;
    localparam int unsigned TH_PHS_AP_MAX = 10;
    localparam int unsigned TH_FM_DP_MIN  = 350;
    localparam int unsigned TH_PSK_DP_MAX = 60;
    localparam int unsigned TH_ASK_AP_MIN = 35;
    localparam int unsigned TH_ASK_AP_MAX = 45;
    localparam int unsigned TH_ASK_AF_MAX = 30;
    localparam int unsigned TH_ASK_DP_MAX = 240;
    localparam int unsigned TH_FSK_AP_MAX = 40;
    localparam int unsigned TH_FSK_AF_MIN = 90;

    // Record fetch / classify controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CLASSIFY,
        ST_OUTPUT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mod_classify_seq_rule_eval.sv
// Combinational priority rule set: maps one feature record (ap, af, dp) to a
// modulation code. Earlier rules take precedence over later ones.
module mod_rule_eval
    import mod_classify_pkg::*;
#(
    parameter int FEAT_W = 32
) (
    input  logic [FEAT_W-1:0] ap,
    input  logic [FEAT_W-1:0] af,
    input  logic [FEAT_W-1:0] dp,
    output logic [2:0]        code
);

    localparam logic [FEAT_W-1:0] AM_AP_MIN  = FEAT_W'(TH_AM_AP_MIN);
    localparam logic [FEAT_W-1:0] AM_AF_MIN  = FEAT_W'(TH_AM_AF_MIN);
    localparam logic [FEAT_W-1:0] AM_DP_MAX  = FEAT_W'(TH_AM_DP_MAX);
    localparam logic [FEAT_W-1:0] PHS_AP_MAX = FEAT_W'(TH_PHS_AP_MAX);
    localparam logic [FEAT_W-1:0] FM_DP_MIN  = FEAT_W'(TH_FM_DP_MIN);
    localparam logic [FEAT_W-1:0] PSK_DP_MAX = FEAT_W'(TH_PSK_DP_MAX);
    localparam logic [FEAT_W-1:0] ASK_AP_MIN = FEAT_W'(TH_ASK_AP_MIN);
    localparam logic [FEAT_W-1:0] ASK_AP_MAX = FEAT_W'(TH_ASK_AP_MAX);
    localparam logic [FEAT_W-1:0] ASK_AF_MAX = FEAT_W'(TH_ASK_AF_MAX);
    localparam logic [FEAT_W-1:0] ASK_DP_MAX = FEAT_W'(TH_ASK_DP_MAX);
    localparam logic [FEAT_W-1:0] FSK_AP_MAX = FEAT_W'(TH_FSK_AP_MAX);
    localparam logic [FEAT_W-1:0] FSK_AF_MIN = FEAT_W'(TH_FSK_AF_MIN);

    logic hit_am;
    logic hit_fm;
    logic hit_psk;
    logic hit_ask;
    logic hit_fsk;

    // Individual rule matches, all unsigned compares
    always_comb begin
        hit_am  = (ap > AM_AP_MIN) && (af > AM_AF_MIN) && (dp < AM_DP_MAX);
        hit_fm  = (ap < PHS_AP_MAX) && (dp > FM_DP_MIN);
        hit_psk = (ap < PHS_AP_MAX) && (dp < PSK_DP_MAX);
        hit_ask = (ap > ASK_AP_MIN) && (ap < ASK_AP_MAX) &&
                  (af < ASK_AF_MAX) && (dp < ASK_DP_MAX);
        hit_fsk = (ap < FSK_AP_MAX) && (af > FSK_AF_MIN);
    end

    // First matching rule wins
    always_comb begin
        code = MOD_UNKNOWN;
        if (hit_am) begin
            code = MOD_AM;
        end else if (hit_fm) begin
            code = MOD_FM;
        end else if (hit_psk) begin
            code = MOD_PSK;
        end else if (hit_ask) begin
            code = MOD_ASK;
        end else if (hit_fsk) begin
            code = MOD_FSK;
        end
    end

endmodule

// File: rtl/mod_classify_seq.sv
// Sequential modulation classifier. Fetches num_rec three-word feature records
// (sigma_ap, sigma_af, sigma_dp) from an external BRAM starting at base_addr,
// classifies each one and hands the code downstream over valid/ready.
// Records are processed strictly one at a time; a stalled output holds off
// the next fetch.
module mod_classify_seq
    import mod_classify_pkg::*;
#(
    parameter int FEAT_W = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_rec,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [FEAT_W-1:0] bram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        mod_type,
    output logic [CNT_W-1:0]  rec_idx
);

    localparam logic [1:0] SLOT_AP = 2'd0;
    localparam logic [1:0] SLOT_AF = 2'd1;
    localparam logic [1:0] SLOT_DP = 2'd2;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  num_q;
    logic [1:0]        slot;

    // Each entry is {en, slot}; the last stage lines up with bram_dout.
    logic [2:0]        tag_pipe [RD_LAT];
    logic [2:0]        tag_last;
    logic              dp_arrive;

    logic [FEAT_W-1:0] ap;
    logic [FEAT_W-1:0] af;
    logic [FEAT_W-1:0] dp;
    logic [2:0]        rule_code;

    assign tag_last  = tag_pipe[RD_LAT-1];
    assign dp_arrive = tag_last[2] && (tag_last[1:0] == SLOT_DP);

    // Delay the read tag by the BRAM latency so data and slot arrive together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= 3'd0;
            end
        end else begin
            tag_pipe[0] <= {bram_en, slot};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Steer returning read data into the feature register named by its tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ap <= '0;
            af <= '0;
            dp <= '0;
        end else if (tag_last[2]) begin
            case (tag_last[1:0])
                SLOT_AP: ap <= bram_dout;
                SLOT_AF: af <= bram_dout;
                SLOT_DP: dp <= bram_dout;
                default: ;
            endcase
        end
    end

    mod_rule_eval #(
        .FEAT_W (FEAT_W)
    ) u_rule_eval (
        .ap   (ap),
        .af   (af),
        .dp   (dp),
        .code (rule_code)
    );

    // Run controller
    //   state       | meaning
    //   ST_IDLE     | waiting for start; latches base_addr / num_rec on accept
    //   ST_ISSUE    | three read cycles: ptr, ptr+1, ptr+2
    //   ST_WAIT     | waiting for the dp word to come back from the BRAM
    //   ST_CLASSIFY | register the rule result and raise out_valid
    //   ST_OUTPUT   | hold the result until out_ready; no reads issued here
    //   ST_DONE     | one-cycle done pulse, back to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            out_valid <= 1'b0;
            mod_type  <= MOD_UNKNOWN;
            rec_idx   <= '0;
            ptr       <= '0;
            num_q     <= '0;
            slot      <= SLOT_AP;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_q   <= num_rec;
                        rec_idx <= '0;
                        ptr     <= base_addr;
                        slot    <= SLOT_AP;
                        if (num_rec == '0) begin
                            // Empty run: report completion without ever going busy
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            busy      <= 1'b1;
                            bram_en   <= 1'b1;
                            bram_addr <= base_addr;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (slot == SLOT_DP) begin
                        // Address wraps modulo 2^ADDR_W by construction
                        bram_en <= 1'b0;
                        ptr     <= ptr + ADDR_W'(3);
                        state   <= ST_WAIT;
                    end else begin
                        slot      <= slot + 2'd1;
                        bram_addr <= bram_addr + ADDR_W'(1);
                    end
                end

                ST_WAIT: begin
                    if (dp_arrive) begin
                        state <= ST_CLASSIFY;
                    end
                end

                ST_CLASSIFY: begin
                    mod_type  <= rule_code;
                    out_valid <= 1'b1;
                    state     <= ST_OUTPUT;
                end

                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rec_idx == num_q - CNT_W'(1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            rec_idx   <= rec_idx + CNT_W'(1);
                            slot      <= SLOT_AP;
                            bram_en   <= 1'b1;
                            bram_addr <= ptr;
                            state     <= ST_ISSUE;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_classify_seq.sv
// Self-checking bench for mod_classify_seq: a BRAM model, a record-level
// reference (expected codes and addresses per run) and one negedge monitor
// that checks every read and every transfer against it.
module tb_mod_classify_seq;

    localparam int FEAT_W = 32;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 12;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  num_rec = '0;
    logic              busy;
    logic              done;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [FEAT_W-1:0] bram_dout;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2:0]        mod_type;
    logic [CNT_W-1:0]  rec_idx;

    always #5 clk = ~clk;

    mod_classify_seq #(
        .FEAT_W (FEAT_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_rec   (num_rec),
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mod_type  (mod_type),
        .rec_idx   (rec_idx)
    );

    // BRAM model with RD_LAT cycles of read latency
    logic [31:0] mem [0:65535];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (bram_en) rd_pipe[0] <= mem[bram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout = rd_pipe[RD_LAT-1];

    typedef struct packed {
        logic [2:0]  code;
        logic [11:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] addr_q[$];
    logic [15:0] addr_log[$];
    int          done_cnt = 0;
    int          ready_mode = 0;   // 0 high, 1 random, 2 low
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference classification rules, straight from the rule table
    function automatic logic [2:0] classify(input int unsigned ap, input int unsigned af,
                                            input int unsigned dp);
        if (ap > 70 && af > 100 && dp < 200) return 3'd1;
        if (ap < 10 && dp > 350) return 3'd2;
        if (ap < 10 && dp < 60) return 3'd3;
        if (ap > 35 && ap < 45 && af < 30 && dp < 240) return 3'd4;
        if (ap < 40 && af > 90) return 3'd5;
        return 3'd0;
    endfunction

    // Downstream ready pattern
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: reads, transfers, output hold under backpressure, done timing
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [2:0] pm = 3'd0;
    logic [11:0] pi = 12'd0;
    logic       expect_done = 1'b0;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done) begin
                chk("done_after_last", 32'(done), 32'd1);
                expect_done = 1'b0;
            end
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", 32'(busy), 32'd0);
            end
            if (bram_en) begin
                addr_log.push_back(bram_addr);
                if (addr_q.size() == 0) chk("bram_en_unexpected", 32'(bram_en), 32'd0);
                else chk("bram_addr", 32'(bram_addr), 32'(addr_q.pop_front()));
            end
            if (out_valid) begin
                chk("no_read_in_output", 32'(bram_en), 32'd0);
                chk("busy_in_output", 32'(busy), 32'd1);
            end
            if (pv && !pr) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_mod", 32'(mod_type), 32'(pm));
                chk("hold_idx", 32'(rec_idx), 32'(pi));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mod_type", 32'(mod_type), 32'(mon_e.code));
                    chk("rec_idx", 32'(rec_idx), 32'(mon_e.idx));
                    if (exp_q.size() == 0) expect_done = 1'b1;
                end
            end
            pv = out_valid;
            pr = out_ready;
            pm = mod_type;
            pi = rec_idx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rec(input logic [15:0] base, input int i, input int unsigned ap,
                            input int unsigned af, input int unsigned dp);
        logic [15:0] a;
        a = base + 16'(3 * i);
        mem[a] = ap;
        mem[a + 16'd1] = af;
        mem[a + 16'd2] = dp;
    endtask

    task automatic expect_run(input logic [15:0] base, input int n);
        logic [15:0] a;
        exp_t        x;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(3 * i);
            x.code = classify(mem[a], mem[a + 16'd1], mem[a + 16'd2]);
            x.idx  = 12'(i);
            exp_q.push_back(x);
            for (int k = 0; k < 3; k++) addr_q.push_back(a + 16'(k));
        end
    endtask

    task automatic pulse_start(input logic [15:0] base, input int n);
        base_addr = base;
        num_rec   = 12'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin
            tick();
            t++;
        end
        if (done_cnt == d0) chk({name, "_timeout"}, 32'(done_cnt), 32'(d0 + 1));
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run(input logic [15:0] base, input int n, input int mode, input string name);
        int d0;
        ready_mode = mode;
        expect_run(base, n);
        d0 = done_cnt;
        pulse_start(base, n);
        wait_done(d0, name);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_bram_en"}, 32'(bram_en), 32'd0);
        chk({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_mod_type"}, 32'(mod_type), 32'd0);
        chk({tag, "_rec_idx"}, 32'(rec_idx), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        int          k;
        int          n;
        logic [15:0] b;
        logic [15:0] wrap_exp [6];
        logic [2:0]  five_exp [5];

        // Pin the reference rules with hand-computed cases
        chk("model_am", 32'(classify(80, 120, 150)), 32'd1);
        chk("model_fm", 32'(classify(5, 0, 400)), 32'd2);
        chk("model_psk", 32'(classify(5, 0, 50)), 32'd3);
        chk("model_ask", 32'(classify(40, 20, 230)), 32'd4);
        chk("model_fsk", 32'(classify(30, 95, 300)), 32'd5);
        chk("model_none", 32'(classify(50, 50, 300)), 32'd0);
        chk("model_bnd_am", 32'(classify(70, 101, 199)), 32'd0);
        chk("model_bnd_fm", 32'(classify(9, 0, 351)), 32'd2);
        chk("model_bnd_psk", 32'(classify(10, 0, 50)), 32'd0);
        chk("model_bnd_ask", 32'(classify(45, 10, 100)), 32'd0);

        // Reset state
        repeat (3) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_rst");

        // Single AM record: first-read timing and latency
        load_rec(16'h0100, 0, 80, 120, 150);
        ready_mode = 0;
        expect_run(16'h0100, 1);
        d0 = done_cnt;
        chk("busy_T", 32'(busy), 32'd0);
        pulse_start(16'h0100, 1);
        chk("busy_T1", 32'(busy), 32'd1);
        chk("bram_en_T1", 32'(bram_en), 32'd1);
        chk("bram_addr_T1", 32'(bram_addr), 32'h0100);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("latency", 32'(k), 32'd5);
        chk("am_mod_type", 32'(mod_type), 32'd1);
        chk("am_rec_idx", 32'(rec_idx), 32'd0);
        wait_done(d0, "am_run");

        // Each rule in turn
        five_exp = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        load_rec(16'h0200, 0, 5, 0, 400);
        load_rec(16'h0200, 1, 5, 0, 50);
        load_rec(16'h0200, 2, 40, 20, 230);
        load_rec(16'h0200, 3, 30, 95, 300);
        load_rec(16'h0200, 4, 50, 50, 300);
        for (int i = 0; i < 5; i++)
            chk("five_model", 32'(classify(mem[16'h0200 + 16'(3*i)], mem[16'h0201 + 16'(3*i)],
                                           mem[16'h0202 + 16'(3*i)])), 32'(five_exp[i]));
        run(16'h0200, 5, 0, "five_run");

        // Threshold boundaries, with random backpressure
        load_rec(16'h0300, 0, 70, 101, 199);
        load_rec(16'h0300, 1, 9, 0, 351);
        load_rec(16'h0300, 2, 10, 0, 50);
        load_rec(16'h0300, 3, 45, 10, 100);
        run(16'h0300, 4, 1, "bnd_run");

        // Address wrap
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
        load_rec(16'hFFFE, 0, 80, 120, 150);
        load_rec(16'hFFFE, 1, 5, 0, 400);
        addr_log.delete();
        run(16'hFFFE, 2, 0, "wrap_run");
        chk("wrap_count", 32'(addr_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < addr_log.size(); i++)
            chk("wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));

        // Backpressure stall with an ignored start pulse
        load_rec(16'h0400, 0, 40, 20, 230);
        load_rec(16'h0400, 1, 30, 95, 300);
        ready_mode = 2;
        expect_run(16'h0400, 2);
        d0 = done_cnt;
        pulse_start(16'h0400, 2);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("stall_reach_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_bram_en", 32'(bram_en), 32'd0);
            chk("stall_mod", 32'(mod_type), 32'(exp_q[0].code));
            chk("stall_idx", 32'(rec_idx), 32'd0);
            if (c == 3) begin
                base_addr = 16'h0900;
                num_rec   = 12'd5;
                start     = 1'b1;
            end
            if (c == 4) start = 1'b0;
            tick();
        end
        start = 1'b0;
        ready_mode = 0;
        wait_done(d0, "stall_run");

        // Empty run
        d0 = done_cnt;
        pulse_start(16'h0500, 0);
        chk("zero_done_T1", 32'(done), 32'd1);
        chk("zero_busy_T1", 32'(busy), 32'd0);
        tick();
        chk("zero_done_T2", 32'(done), 32'd0);
        chk("zero_busy_T2", 32'(busy), 32'd0);
        chk("zero_done_count", 32'(done_cnt), 32'(d0 + 1));

        // Reset during WAIT
        load_rec(16'h0600, 0, 80, 120, 150);
        load_rec(16'h0600, 1, 5, 0, 50);
        load_rec(16'h0600, 2, 5, 0, 400);
        ready_mode = 0;
        expect_run(16'h0600, 3);
        pulse_start(16'h0600, 3);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        exp_q.delete();
        addr_q.delete();
        d0 = done_cnt;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        chk("idle_after_reset", 32'(busy), 32'd0);
        load_rec(16'h0000, 0, 9, 0, 351);
        run(16'h0000, 1, 0, "post_reset_run");

        // Randomised back-to-back runs
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 6);
            b = 16'($urandom);
            for (int i = 0; i < n; i++)
                load_rec(b, i, $urandom_range(0, 420), $urandom_range(0, 420),
                         $urandom_range(0, 420));
            run(b, n, $urandom_range(0, 1), "rand_run");
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
